// File: rtl/ahb_matrix_slave_port.sv
// AHB multi-layer matrix output stage: arbitrates the masters requesting this
// slave port, muxes the granted address phase and the data-phase owner's write
// data onto the slave, and returns per-master ready plus broadcast read data.
module ahb_matrix_slave_port #(
    parameter int MNUM = 8
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic [MNUM*32-1:0]   im_haddr,
    input  logic [MNUM*2-1:0]    im_htrans,
    input  logic [MNUM-1:0]      im_hwrite,
    input  logic [MNUM*3-1:0]    im_hsize,
    input  logic [MNUM*3-1:0]    im_hburst,
    input  logic [MNUM*4-1:0]    im_hprot,
    input  logic [MNUM*32-1:0]   im_hwdata,
    output logic [31:0]          om_hrdata,
    output logic [MNUM-1:0]      om_hready,
    output logic [1:0]           om_hresp,
    output logic [31:0]          os_haddr,
    output logic [1:0]           os_htrans,
    output logic                 os_hwrite,
    output logic [2:0]           os_hsize,
    output logic [2:0]           os_hburst,
    output logic [3:0]           os_hprot,
    output logic [31:0]          os_hwdata,
    output logic                 os_hsel,
    input  logic [31:0]          is_hrdata,
    input  logic                 is_hready,
    input  logic [1:0]           is_hresp
);

    localparam int MW = (MNUM > 1) ? $clog2(MNUM) : 1;

    // Arbitration and data-phase tracking state (all control, all reset)
    logic [MW-1:0] r_owner;
    logic          r_wlock;
    logic [MW-1:0] r_wmaster;
    logic          r_dph_valid;
    logic [MW-1:0] r_dph_master;

    logic [MNUM-1:0] w_req;
    logic            w_gnt_vld;
    logic [MW-1:0]   w_gnt;

    // Request vector: NONSEQ or SEQ from each master (HTRANS[1])
    always_comb begin
        w_req = '0;
        for (int m = 0; m < MNUM; m++) begin
            w_req[m] = im_htrans[2*m+1];
        end
    end

    // Grant: frozen during wait states, bursts held by owner, else round-robin after owner
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        if (r_wlock) begin
            w_gnt_vld = 1'b1;
            w_gnt     = r_wmaster;
        end else if (im_htrans[2*int'(r_owner)]) begin
            // SEQ (11) and BUSY (01) both have bit 0 set: keep the burst intact
            w_gnt_vld = 1'b1;
            w_gnt     = r_owner;
        end else begin
            for (int k = 1; k <= MNUM; k++) begin
                if (!w_gnt_vld && w_req[(int'(r_owner) + k) % MNUM]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = MW'((int'(r_owner) + k) % MNUM);
                end
            end
        end
    end

    // Address/control mux from the granted master; all zero when nobody is granted
    always_comb begin
        os_haddr  = '0;
        os_htrans = '0;
        os_hwrite = 1'b0;
        os_hsize  = '0;
        os_hburst = '0;
        os_hprot  = '0;
        os_hsel   = 1'b0;
        if (w_gnt_vld) begin
            os_haddr  = im_haddr[32*int'(w_gnt) +: 32];
            os_htrans = im_htrans[2*int'(w_gnt) +: 2];
            os_hwrite = im_hwrite[int'(w_gnt)];
            os_hsize  = im_hsize[3*int'(w_gnt) +: 3];
            os_hburst = im_hburst[3*int'(w_gnt) +: 3];
            os_hprot  = im_hprot[4*int'(w_gnt) +: 4];
            os_hsel   = (im_htrans[2*int'(w_gnt) +: 2] != 2'b00);
        end
    end

    // Write data always follows the registered data-phase owner
    assign os_hwdata = im_hwdata[32*int'(r_dph_master) +: 32];

    // Response path is a pure pass-through, so multi-cycle ERROR is preserved
    assign om_hrdata = is_hrdata;
    assign om_hresp  = is_hresp;

    // Per-master ready: data-phase stall AND address-phase acceptance
    always_comb begin
        om_hready = '0;
        for (int m = 0; m < MNUM; m++) begin
            om_hready[m] = ((r_dph_valid && (int'(r_dph_master) == m)) ? is_hready : 1'b1)
                         & ((im_htrans[2*m +: 2] != 2'b00)
                            ? (w_gnt_vld && (int'(w_gnt) == m) && is_hready) : 1'b1);
        end
    end

    // Owner, wait-state freeze and data-phase tracking
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_owner      <= MW'(MNUM - 1);
            r_wlock      <= 1'b0;
            r_wmaster    <= '0;
            r_dph_valid  <= 1'b0;
            r_dph_master <= '0;
        end else if (is_hready) begin
            r_wlock <= 1'b0;
            if (w_gnt_vld) begin
                r_owner      <= w_gnt;
                r_dph_valid  <= w_req[int'(w_gnt)];
                r_dph_master <= w_gnt;
            end else begin
                r_dph_valid  <= 1'b0;
            end
        end else if (w_gnt_vld) begin
            r_wlock   <= 1'b1;
            r_wmaster <= w_gnt;
        end
    end

endmodule

// File: tb/tb_ahb_matrix_slave_port.sv
// Self-checking bench for ahb_matrix_slave_port: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the port.
module tb_ahb_matrix_slave_port;

    localparam int MNUM = 4;

    logic hclk = 1'b0;
    logic hreset;

    logic [31:0] a_addr  [MNUM];
    logic [1:0]  a_trans [MNUM];
    logic        a_write [MNUM];
    logic [2:0]  a_size  [MNUM];
    logic [2:0]  a_burst [MNUM];
    logic [3:0]  a_prot  [MNUM];
    logic [31:0] a_wdata [MNUM];

    logic [MNUM*32-1:0] im_haddr;
    logic [MNUM*2-1:0]  im_htrans;
    logic [MNUM-1:0]    im_hwrite;
    logic [MNUM*3-1:0]  im_hsize;
    logic [MNUM*3-1:0]  im_hburst;
    logic [MNUM*4-1:0]  im_hprot;
    logic [MNUM*32-1:0] im_hwdata;
    logic [31:0]        om_hrdata;
    logic [MNUM-1:0]    om_hready;
    logic [1:0]         om_hresp;
    logic [31:0]        os_haddr;
    logic [1:0]         os_htrans;
    logic               os_hwrite;
    logic [2:0]         os_hsize;
    logic [2:0]         os_hburst;
    logic [3:0]         os_hprot;
    logic [31:0]        os_hwdata;
    logic               os_hsel;
    logic [31:0]        is_hrdata;
    logic               is_hready;
    logic [1:0]         is_hresp;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_owner, m_wlock, m_wmaster, m_dph_valid, m_dph_master;
    int nx_owner, nx_wlock, nx_wmaster, nx_dph_valid, nx_dph_master;

    always #5 hclk = ~hclk;

    always_comb begin
        im_haddr  = '0;
        im_htrans = '0;
        im_hwrite = '0;
        im_hsize  = '0;
        im_hburst = '0;
        im_hprot  = '0;
        im_hwdata = '0;
        for (int m = 0; m < MNUM; m++) begin
            im_haddr[32*m +: 32]  = a_addr[m];
            im_htrans[2*m +: 2]   = a_trans[m];
            im_hwrite[m]          = a_write[m];
            im_hsize[3*m +: 3]    = a_size[m];
            im_hburst[3*m +: 3]   = a_burst[m];
            im_hprot[4*m +: 4]    = a_prot[m];
            im_hwdata[32*m +: 32] = a_wdata[m];
        end
    end

    ahb_matrix_slave_port #(.MNUM(MNUM)) dut (
        .hclk(hclk), .hreset(hreset),
        .im_haddr(im_haddr), .im_htrans(im_htrans), .im_hwrite(im_hwrite),
        .im_hsize(im_hsize), .im_hburst(im_hburst), .im_hprot(im_hprot),
        .im_hwdata(im_hwdata),
        .om_hrdata(om_hrdata), .om_hready(om_hready), .om_hresp(om_hresp),
        .os_haddr(os_haddr), .os_htrans(os_htrans), .os_hwrite(os_hwrite),
        .os_hsize(os_hsize), .os_hburst(os_hburst), .os_hprot(os_hprot),
        .os_hwdata(os_hwdata), .os_hsel(os_hsel),
        .is_hrdata(is_hrdata), .is_hready(is_hready), .is_hresp(is_hresp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Who wins this cycle, stated from the arbitration rules
    function automatic void model_grant(output bit v, output int g);
        v = 1'b0;
        g = 0;
        if (m_wlock != 0) begin
            v = 1'b1;
            g = m_wmaster;
        end else if (a_trans[m_owner] == 2'b11 || a_trans[m_owner] == 2'b01) begin
            v = 1'b1;
            g = m_owner;
        end else begin
            for (int k = 1; k <= MNUM; k++) begin
                int c;
                c = (m_owner + k) % MNUM;
                if (!v && (a_trans[c] == 2'b10 || a_trans[c] == 2'b11)) begin
                    v = 1'b1;
                    g = c;
                end
            end
        end
    endfunction

    // Compare every output against the model, then prepare the next model state
    task automatic sample();
        bit v;
        int g;
        logic [MNUM-1:0] e_rdy;
        logic d, a;
        @(negedge hclk);
        model_grant(v, g);
        chk("haddr",  os_haddr,  v ? a_addr[g] : 32'h0);
        chk("htrans", {30'h0, os_htrans}, v ? {30'h0, a_trans[g]} : 32'h0);
        chk("hwrite", {31'h0, os_hwrite}, v ? {31'h0, a_write[g]} : 32'h0);
        chk("hsize",  {29'h0, os_hsize},  v ? {29'h0, a_size[g]} : 32'h0);
        chk("hburst", {29'h0, os_hburst}, v ? {29'h0, a_burst[g]} : 32'h0);
        chk("hprot",  {28'h0, os_hprot},  v ? {28'h0, a_prot[g]} : 32'h0);
        chk("hsel",   {31'h0, os_hsel},   (v && a_trans[g] != 2'b00) ? 32'h1 : 32'h0);
        chk("hwdata", os_hwdata, a_wdata[m_dph_master]);
        chk("hrdata", om_hrdata, is_hrdata);
        chk("hresp",  {30'h0, om_hresp}, {30'h0, is_hresp});
        for (int m = 0; m < MNUM; m++) begin
            d = (m_dph_valid != 0 && m_dph_master == m) ? is_hready : 1'b1;
            a = (a_trans[m] != 2'b00) ? (v && g == m && is_hready) : 1'b1;
            e_rdy[m] = d & a;
        end
        chk("hready", {28'h0, om_hready}, {28'h0, e_rdy});
        nx_owner = m_owner; nx_wlock = m_wlock; nx_wmaster = m_wmaster;
        nx_dph_valid = m_dph_valid; nx_dph_master = m_dph_master;
        if (hreset) begin
            nx_owner = MNUM - 1; nx_wlock = 0; nx_wmaster = 0;
            nx_dph_valid = 0; nx_dph_master = 0;
        end else if (is_hready) begin
            nx_wlock = 0;
            if (v) begin
                nx_owner = g;
                nx_dph_valid = a_trans[g][1];
                nx_dph_master = g;
            end else begin
                nx_dph_valid = 0;
            end
        end else if (v) begin
            nx_wlock = 1;
            nx_wmaster = g;
        end
    endtask

    task automatic commit();
        @(posedge hclk);
        m_owner = nx_owner; m_wlock = nx_wlock; m_wmaster = nx_wmaster;
        m_dph_valid = nx_dph_valid; m_dph_master = nx_dph_master;
        #1;
    endtask

    task automatic idle_all();
        for (int m = 0; m < MNUM; m++) begin
            a_trans[m] = 2'b00;
            a_addr[m]  = 32'h1000 * (m + 1);
            a_write[m] = m[0];
            a_size[m]  = 3'd2;
            a_burst[m] = 3'(m);
            a_prot[m]  = 4'(m + 3);
            a_wdata[m] = 32'hA5A50000 + m;
        end
        is_hready = 1'b1;
        is_hresp  = 2'b00;
        is_hrdata = 32'h0;
    endtask

    task automatic do_reset();
        hreset = 1'b1;
        sample(); commit();
        hreset = 1'b0;
    endtask

    initial begin
        hreset = 1'b1;
        idle_all();
        m_owner = MNUM - 1; m_wlock = 0; m_wmaster = 0; m_dph_valid = 0; m_dph_master = 0;
        @(posedge hclk); #1;
        do_reset();

        // Reset state, no requests
        sample();
        chk("rst_hsel", {31'h0, os_hsel}, 32'h0);
        chk("rst_htrans", {30'h0, os_htrans}, 32'h0);
        chk("rst_haddr", os_haddr, 32'h0);
        chk("rst_hready", {28'h0, om_hready}, 32'hF);
        commit();

        // Single write from master 0
        a_trans[0] = 2'b10; a_addr[0] = 32'h100; a_write[0] = 1'b1; a_wdata[0] = 32'hCAFE0000;
        sample();
        chk("m0_haddr", os_haddr, 32'h100);
        chk("m0_hsel", {31'h0, os_hsel}, 32'h1);
        commit();
        a_trans[0] = 2'b00;
        sample();
        chk("m0_hwdata", os_hwdata, 32'hCAFE0000);
        chk("m0_hready", {31'h0, om_hready[0]}, 32'h1);
        commit();

        // Simultaneous requests from masters 0 and 1 after reset
        do_reset();
        a_trans[0] = 2'b10; a_trans[1] = 2'b10; a_addr[0] = 32'h10; a_addr[1] = 32'h20;
        sample();
        chk("rr_first", os_haddr, 32'h10);
        chk("rr_m1_wait", {31'h0, om_hready[1]}, 32'h0);
        commit();
        a_trans[0] = 2'b00;
        sample();
        chk("rr_second", os_haddr, 32'h20);
        chk("rr_m1_acc", {31'h0, om_hready[1]}, 32'h1);
        commit();
        a_trans[1] = 2'b00;
        sample(); commit();

        // INCR4 from master 2 while master 3 requests
        a_trans[2] = 2'b10; a_addr[2] = 32'h300; a_trans[3] = 2'b10; a_addr[3] = 32'h400;
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin
                a_trans[2] = 2'b11;
                a_addr[2]  = 32'h300 + 4 * b;
            end
            sample();
            chk("burst_haddr", os_haddr, 32'h300 + 4 * b);
            chk("burst_m3_wait", {31'h0, om_hready[3]}, 32'h0);
            commit();
        end
        a_trans[2] = 2'b00;
        sample();
        chk("burst_m3_gnt", os_haddr, 32'h400);
        chk("burst_m3_acc", {31'h0, om_hready[3]}, 32'h1);
        commit();
        a_trans[3] = 2'b00;
        sample(); commit();

        // Two wait states during master 1's read while master 0 requests
        a_trans[1] = 2'b10; a_addr[1] = 32'h200; a_write[1] = 1'b0;
        sample(); commit();
        a_trans[1] = 2'b00; a_trans[0] = 2'b10; a_addr[0] = 32'h500;
        is_hready = 1'b0;
        for (int w = 0; w < 2; w++) begin
            sample();
            chk("ws_m1_stall", {31'h0, om_hready[1]}, 32'h0);
            chk("ws_frozen", os_haddr, 32'h500);
            commit();
        end
        is_hready = 1'b1; is_hrdata = 32'hDEADBEEF;
        sample();
        chk("ws_rdata", om_hrdata, 32'hDEADBEEF);
        chk("ws_m1_done", {31'h0, om_hready[1]}, 32'h1);
        commit();
        a_trans[0] = 2'b00; is_hrdata = 32'h0;

        // Two-cycle ERROR response on master 0's data phase
        is_hready = 1'b0; is_hresp = 2'b01;
        sample();
        chk("err1_resp", {30'h0, om_hresp}, 32'h1);
        chk("err1_rdy", {31'h0, om_hready[0]}, 32'h0);
        commit();
        is_hready = 1'b1;
        sample();
        chk("err2_resp", {30'h0, om_hresp}, 32'h1);
        chk("err2_rdy", {31'h0, om_hready[0]}, 32'h1);
        commit();
        is_hresp = 2'b00;

        // Reset in the middle of a transfer
        a_trans[2] = 2'b10; a_addr[2] = 32'h600;
        sample(); commit();
        a_trans[2] = 2'b00; is_hready = 1'b0;
        do_reset();
        sample();
        chk("mid_rst_rdy", {28'h0, om_hready}, 32'hF);
        commit();
        is_hready = 1'b1;
        a_trans[1] = 2'b10; a_trans[3] = 2'b10; a_addr[1] = 32'h700; a_addr[3] = 32'h800;
        sample();
        chk("mid_rst_rr", os_haddr, 32'h700);
        commit();
        idle_all();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            hreset = ($urandom_range(0, 99) == 0);
            for (int m = 0; m < MNUM; m++) begin
                if ($urandom_range(0, 2) == 0) a_trans[m] = 2'($urandom);
                if ($urandom_range(0, 3) == 0) a_addr[m] = $urandom;
                a_write[m] = 1'($urandom);
                a_size[m]  = 3'($urandom);
                a_burst[m] = 3'($urandom);
                a_prot[m]  = 4'($urandom);
                a_wdata[m] = $urandom;
            end
            is_hready = ($urandom_range(0, 3) != 0);
            is_hresp  = 2'($urandom);
            is_hrdata = $urandom;
            sample();
            commit();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_matrix_slave_port.md
Name: ahb_matrix_slave_port

Overview:
- Output stage of a multi-layer AHB matrix. One instance sits in front of each slave port, including the default slave.
- Arbitrates among up to MNUM masters whose input stages present a request to this slave.
- Muxes the granted master's address/control onto the slave and the data-phase owner's write data.
- Returns per-master ready plus broadcast read data and response.

Parameters:
MNUM, 8, number of master inputs (legal 1..16)

Ports:
hclk  in  1  clock; all state changes on rising edge
hreset  in  1  synchronous active-high reset
im_haddr  in  MNUM*32  per-master HADDR, master m at [32m+:32]
im_htrans  in  MNUM*2  per-master HTRANS towards this port; IDLE=00 when the master does not target this port
im_hwrite  in  MNUM  per-master HWRITE
im_hsize  in  MNUM*3  per-master HSIZE
im_hburst  in  MNUM*3  per-master HBURST
im_hprot  in  MNUM*4  per-master HPROT
im_hwdata  in  MNUM*32  per-master HWDATA
om_hrdata  out  32  slave HRDATA, broadcast to all masters
om_hready  out  MNUM  per-master ready as seen from this port
om_hresp  out  2  slave HRESP, broadcast
os_haddr  out  32  to slave
os_htrans  out  2  to slave
os_hwrite  out  1  to slave
os_hsize  out  3  to slave
os_hburst  out  3  to slave
os_hprot  out  4  to slave
os_hwdata  out  32  to slave
os_hsel  out  1  to slave
is_hrdata  in  32  from slave
is_hready  in  1  from slave (HREADYOUT)
is_hresp  in  2  from slave

Behaviour:
- HTRANS encoding: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11. req[m] = im_htrans[2m+1].
- Registers:
  - owner: last master whose address was accepted. Reset MNUM-1, so master 0 wins first.
  - wlock/wmaster: grant frozen during a slave wait state. Reset 0/0.
  - dph_valid/dph_master: data-phase owner. Reset 0/0.
- Grant (combinational), first matching rule wins:
  - (a) wlock=1 -> wmaster.
  - (b) im_htrans[owner] is SEQ or BUSY -> owner; bursts are never broken.
  - (c) round-robin over req[], searching from owner+1 upward with wrap-around.
  - (d) none -> no grant.
- Freeze: when is_hready=0 and a grant is valid, set wlock=1 and wmaster=grant. Clear wlock on any cycle with is_hready=1.
- Address mux, with grant g:
  - os_haddr/hwrite/hsize/hburst/hprot/htrans come from master g.
  - os_hsel=1 iff im_htrans[g]!=IDLE.
  - No grant: all address/control outputs 0, os_hsel=0.
- When is_hready=1 and a grant is valid: owner<=g, dph_valid<=req[g] (BUSY creates no data phase), dph_master<=g.
- When is_hready=1 and no grant: dph_valid<=0.
- When is_hready=0: owner and dph_* hold.
- os_hwdata = im_hwdata[dph_master], always (no qualification).
- om_hrdata=is_hrdata and om_hresp=is_hresp, combinational pass-through. Two-cycle ERROR passes unchanged.
- om_hready[m] = D & A, where:
  - D = is_hready if (dph_valid and dph_master==m), else 1.
  - A = (g==m and is_hready) if im_htrans[m]!=IDLE, else 1.
  - Result: a requesting but ungranted master is held with ready=0 and must keep its address stable.
- om_hready is combinational; no extra latency. A transfer accepted in cycle N has its data phase in cycle N+1 onward.
- MNUM=1 degenerates to a pass-through with data-phase tracking.
- Reset mid-transfer drops the data phase (dph_valid=0) and restarts arbitration from master 0.

Test Plan:
- Reset, no requests -> os_hsel=0, os_htrans=00, os_haddr=0, om_hready=all 1.
- Master 0 NONSEQ write to 0x100, is_hready=1 -> os_haddr=0x100, os_hsel=1. Next cycle os_hwdata=im_hwdata[0], om_hready[0]=1.
- Masters 0 and 1 issue NONSEQ simultaneously after reset -> master 0 granted and om_hready[1]=0. Next cycle master 1 granted, om_hready[1]=1 when accepted.
- Master 2 runs an INCR4 (NONSEQ then SEQ x3) while master 3 requests -> master 3 stays ready=0 until master 2 issues a non-SEQ/BUSY. Order per owner: 2,2,2,2,3.
- Slave inserts 2 wait states (is_hready=0) during master 1's read while master 0 requests -> grant frozen on the presented master; om_hready[1]=0 for 2 cycles, then is_hrdata=0xDEADBEEF reaches om_hrdata with om_hready[1]=1.
- Slave returns ERROR (cycle 1: hready=0, hresp=01; cycle 2: hready=1, hresp=01) -> same values on om_hresp and om_hready[owner].
